// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types, field positions and helpers for the fetch stage.
//   state_e  : fetch controller states
//   JIDX_MSB : top bit of the J-type jump index inside an instruction word
//   IMM_MSB  : top bit of the 16-bit immediate inside an instruction word
//   sext16() : sign-extend a 16-bit immediate to 32 bits
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int JIDX_MSB = 25;
  localparam int IMM_MSB  = 15;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_timer.sv
// fetch_timer: 8-bit up-counter used to bound how long a memory request may
// wait for its acknowledge.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low; count returns to 0
//   clr     : synchronous clear to 0 (wins over en)
//   en      : advance the count by one
//   expired : count has reached LIMIT (combinational from the count flop)
module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIM);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage sitting after the program counter.
// Issues a req/ack read to instruction memory for each valid PC, captures the
// returned word into the instruction register and holds it until decode takes
// it. Stalls the PC while busy and raises a sticky fault on a misaligned PC or
// a memory that never answers.
//   clk, reset             : clock (rising) and async active-low reset
//   pc_addr, pc_valid      : address to fetch and its valid strobe
//   flush                  : drop in-flight or held instruction (taken jump)
//   imem_req, imem_addr    : registered memory request and address
//   imem_ack, imem_rdata   : memory response strobe and data
//   ir_valid, ir, ir_pc    : instruction register, its valid and its address
//   ir_ready               : decode consumes the IR this cycle
//   insn_index, sign_imm   : decoded jump index / sign-extended immediate
//   fetch_busy             : PC must hold (controller not idle)
//   fetch_fault            : sticky fault, cleared only by reset
//
// state | meaning
// IDLE  | no fetch outstanding, waiting for pc_valid
// REQ   | request on the bus, waiting for imem_ack (may be marked for drop)
// HOLD  | IR holds a valid word, waiting for decode or flush
// FAULT | misaligned PC or timeout seen; only reset leaves
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  output logic [25:0]       insn_index,
  output logic [31:0]       sign_imm,
  output logic              fetch_busy,
  output logic              fetch_fault
);

  state_e            state_q,    state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] ir_q,       ir_d;
  logic [ADDR_W-1:0] ir_pc_q,    ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fault_q,    fault_d;
  logic              drop_q,     drop_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;
  logic accept_pc;

  fetch_timer #(
    .LIMIT (TIMEOUT - 1)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fault_d     = fault_q;
    drop_d      = drop_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    accept_pc   = 1'b0;

    case (state_q)
      IDLE: begin
        accept_pc = pc_valid;
      end

      REQ: begin
        // The request is never retracted on flush; the response still has to
        // be drained so it cannot be mistaken for the next fetch's data.
        drop_d = drop_q | flush;
        if (imem_ack) begin
          imem_req_d = 1'b0;
          drop_d     = 1'b0;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = imem_addr_q;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (tmr_expired) begin
          imem_req_d = 1'b0;
          drop_d     = 1'b0;
          fault_d    = 1'b1;
          state_d    = FAULT;
        end else begin
          tmr_en = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
          accept_pc  = pc_valid;
        end
      end

      FAULT: begin
        imem_req_d = 1'b0;
        ir_valid_d = 1'b0;
        fault_d    = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared launch path for IDLE and the back-to-back case out of HOLD.
    if (accept_pc) begin
      if (pc_addr[1:0] == 2'b00) begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_addr;
        drop_d      = 1'b0;
        tmr_clr     = 1'b1;
        state_d     = REQ;
      end else begin
        fault_d = 1'b1;
        state_d = FAULT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fault_q     <= fault_d;
      drop_q      <= drop_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_busy  = (state_q != IDLE);
  assign insn_index  = ir_q[JIDX_MSB:0];
  assign sign_imm    = sext16(ir_q[IMM_MSB:0]);

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] pc_addr = '0;
  logic              pc_valid = 1'b0;
  logic              flush;
  logic              flush_drv = 1'b0;
  logic              flush_rsp;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready = 1'b0;
  logic [25:0]       insn_index;
  logic [31:0]       sign_imm;
  logic              fetch_busy;
  logic              fetch_fault;

  assign flush = flush_drv | flush_rsp;

  ifetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid),
    .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready), .insn_index(insn_index),
    .sign_imm(sign_imm), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  int          rsp_lat   = 0;
  bit          rsp_mute  = 1'b0;
  bit          rsp_flush = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: explicit entries, else a fixed hash of the address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_sext(input logic [31:0] w);
    int v;
    v = int'(w[15:0]);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  // Memory responder: answers each request after rsp_lat idle cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    flush_rsp  = 1'b0;
    forever begin
      @(posedge clk); #1;
      imem_rdata = $urandom;
      if (imem_req && !rsp_mute) begin
        repeat (rsp_lat) begin
          @(posedge clk); #1;
          imem_rdata = $urandom;
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_rd(imem_addr);
        flush_rsp  = rsp_flush;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        flush_rsp  = 1'b0;
        imem_rdata = $urandom;
      end
    end
  end

  // Monitor: whenever the IR is presented, compare against the scoreboard head;
  // retire the entry when decode takes it or it is flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ir_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ir_valid", 64'(ir_valid), 64'd0);
        end else begin
          e = sb[0];
          chk("ir",         64'(ir),         64'(e.word));
          chk("ir_pc",      64'(ir_pc),      64'(e.pc));
          chk("insn_index", 64'(insn_index), 64'(e.word[25:0]));
          chk("sign_imm",   64'(sign_imm),   64'(exp_sext(e.word)));
          if (ir_ready || flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.word = mem_rd(a);
    e.pc   = a;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a);
    pc_addr  = a;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic wait_ir();
    int n = 0;
    while (!ir_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wait_ir_valid", 64'(ir_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fetch_busy && n < 50) begin
      tick();
      n++;
    end
    chk("wait_idle", 64'(fetch_busy), 64'd0);
  endtask

  task automatic consume(input int k);
    repeat (k) tick();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_imem_req"},   64'(imem_req),    64'd0);
    chk({tag, "_imem_addr"},  64'(imem_addr),   64'd0);
    chk({tag, "_ir"},         64'(ir),          64'd0);
    chk({tag, "_ir_pc"},      64'(ir_pc),       64'd0);
    chk({tag, "_ir_valid"},   64'(ir_valid),    64'd0);
    chk({tag, "_busy"},       64'(fetch_busy),  64'd0);
    chk({tag, "_fault"},      64'(fetch_fault), 64'd0);
    chk({tag, "_sign_imm"},   64'(sign_imm),    64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] a, b, ir_save;
    int mode, n, n_req;

    mem[32'h0000_0040] = 32'h0800_0010;
    mem[32'h0000_0100] = 32'h1000_FFFC;
    mem[32'h0000_0200] = 32'h0000_8000;
    mem[32'h0000_0204] = 32'hFFFF_7FFF;

    #1 reset = 1'b0;
    #3;
    check_all_zero("por");
    tick();
    reset = 1'b1;
    tick();

    // Zero-wait fetch with latency checks.
    rsp_lat = 0;
    push(32'h40);
    issue(32'h40);
    chk("zw_req",      64'(imem_req),   64'd1);
    chk("zw_addr",     64'(imem_addr),  64'h40);
    chk("zw_busy",     64'(fetch_busy), 64'd1);
    chk("zw_valid_n",  64'(ir_valid),   64'd0);
    tick();
    chk("zw_valid",    64'(ir_valid),   64'd1);
    chk("zw_ir",       64'(ir),         64'h0800_0010);
    chk("zw_ir_pc",    64'(ir_pc),      64'h40);
    chk("zw_index",    64'(insn_index), 64'h10);
    chk("zw_busy2",    64'(fetch_busy), 64'd1);

    // Back-pressure, then back-to-back fetch.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ir",  64'(ir),       64'h0800_0010);
      chk("bp_req", 64'(imem_req), 64'd0);
      chk("bp_vld", 64'(ir_valid), 64'd1);
    end
    rsp_lat  = 2;
    pc_addr  = 32'h80;
    pc_valid = 1'b1;
    ir_ready = 1'b1;
    push(32'h80);
    tick();
    pc_valid = 1'b0;
    ir_ready = 1'b0;
    chk("b2b_req",   64'(imem_req),  64'd1);
    chk("b2b_addr",  64'(imem_addr), 64'h80);
    chk("b2b_valid", 64'(ir_valid),  64'd0);
    wait_ir();
    consume(1);
    wait_idle();

    // Sign-extension examples.
    rsp_lat = 1;
    push(32'h100); issue(32'h100); wait_ir();
    chk("sext_fffc", 64'(sign_imm), 64'hFFFF_FFFC);
    consume(0);
    push(32'h200); issue(32'h200); wait_ir();
    chk("sext_8000", 64'(sign_imm), 64'hFFFF_8000);
    consume(0);
    push(32'h204); issue(32'h204); wait_ir();
    chk("sext_7fff", 64'(sign_imm), 64'h0000_7FFF);
    consume(0);
    wait_idle();

    // Flush on the 2nd REQ cycle, ack on the 4th.
    rsp_lat = 3;
    ir_save = ir;
    issue(32'h300);
    tick();
    flush_drv = 1'b1;
    tick();
    flush_drv = 1'b0;
    chk("fr_req_held", 64'(imem_req), 64'd1);
    wait_idle();
    chk("fr_valid", 64'(ir_valid), 64'd0);
    chk("fr_ir",    64'(ir),       64'(ir_save));

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      a = $urandom & 32'hFFFF_FFFC;
      b = $urandom & 32'hFFFF_FFFC;
      mode = $urandom_range(0, 4);
      ir_save = ir;
      case (mode)
        0: begin
          rsp_lat = $urandom_range(0, 4);
          push(a); issue(a); wait_ir();
          consume($urandom_range(0, 3));
        end
        1: begin
          rsp_lat = $urandom_range(1, 5);
          issue(a);
          repeat ($urandom_range(0, 1)) tick();
          flush_drv = 1'b1;
          tick();
          flush_drv = 1'b0;
          wait_idle();
          chk("rf_valid", 64'(ir_valid), 64'd0);
          chk("rf_ir",    64'(ir),       64'(ir_save));
        end
        2: begin
          rsp_lat   = $urandom_range(0, 4);
          rsp_flush = 1'b1;
          issue(a);
          wait_idle();
          rsp_flush = 1'b0;
          chk("fa_valid", 64'(ir_valid), 64'd0);
          chk("fa_ir",    64'(ir),       64'(ir_save));
        end
        3: begin
          rsp_lat = $urandom_range(0, 3);
          push(a); issue(a); wait_ir();
          repeat ($urandom_range(0, 2)) tick();
          flush_drv = 1'b1;
          ir_ready  = 1'($urandom_range(0, 1));
          tick();
          flush_drv = 1'b0;
          ir_ready  = 1'b0;
          chk("fh_valid", 64'(ir_valid),   64'd0);
          chk("fh_busy",  64'(fetch_busy), 64'd0);
        end
        default: begin
          rsp_lat = $urandom_range(0, 3);
          push(a); issue(a); wait_ir();
          pc_addr  = b;
          pc_valid = 1'b1;
          ir_ready = 1'b1;
          push(b);
          tick();
          pc_valid = 1'b0;
          ir_ready = 1'b0;
          chk("rb_req",  64'(imem_req),  64'd1);
          chk("rb_addr", 64'(imem_addr), 64'(b));
          wait_ir();
          consume($urandom_range(0, 2));
        end
      endcase
      wait_idle();
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Reset during a pending request; the late ack must be ignored.
    rsp_lat = 4;
    issue(32'h500);
    tick();
    tick();
    pulse_reset();
    repeat (6) tick();
    chk("late_valid", 64'(ir_valid),   64'd0);
    chk("late_busy",  64'(fetch_busy), 64'd0);
    chk("late_ir",    64'(ir),         64'd0);

    // Misaligned PC.
    issue(32'h42);
    chk("mis_fault", 64'(fetch_fault), 64'd1);
    chk("mis_req",   64'(imem_req),    64'd0);
    chk("mis_busy",  64'(fetch_busy),  64'd1);
    n = 0;
    repeat (4) begin
      tick();
      if (imem_req) n++;
    end
    chk("mis_no_req", 64'(n), 64'd0);
    pulse_reset();

    // Timeout: memory never answers.
    rsp_mute = 1'b1;
    issue(32'h600);
    n = 0;
    n_req = 0;
    while (!fetch_fault && n < 40) begin
      if (imem_req) n_req++;
      tick();
      n++;
    end
    chk("to_req_cycles", 64'(n_req),       64'(TIMEOUT));
    chk("to_fault",      64'(fetch_fault), 64'd1);
    chk("to_req_low",    64'(imem_req),    64'd0);
    repeat (5) tick();
    chk("to_sticky", 64'(fetch_fault), 64'd1);
    chk("to_busy",   64'(fetch_busy),  64'd1);
    chk("to_valid",  64'(ir_valid),    64'd0);
    pulse_reset();
    rsp_mute = 1'b0;

    repeat (3) tick();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
